// File: rtl/pipeline_stage_flush_if.sv
// rtl/pipeline_stage_flush_if.sv - upstream/downstream transaction bundle for pipeline_stage_flush
interface pipeline_stage_flush_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 4
);
  logic [ADDRESS_WIDTH-1:0] in_address;
  logic [ID_WIDTH-1:0]      in_id;
  logic                     in_valid;
  logic                     out_stall;
  logic [ADDRESS_WIDTH-1:0] out_address;
  logic [ID_WIDTH-1:0]      out_id;
  logic                     out_valid;
  logic                     in_stall;

  modport master (
    output in_address, in_id, in_valid, in_stall,
    input  out_stall, out_address, out_id, out_valid
  );

  modport slave (
    input  in_address, in_id, in_valid, in_stall,
    output out_stall, out_address, out_id, out_valid
  );
endinterface

// File: rtl/pipeline_stage_flush.sv
// rtl/pipeline_stage_flush.sv - FIFO pipeline stage with address offset, flush and stall counter
module pipeline_stage_flush #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 4,
  parameter int DEPTH         = 2,
  parameter int SUBTRACT      = 0,
  localparam int OCC_W        = $clog2(DEPTH + 1),
  localparam int PTR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] stage_offset,
  input  logic                     flush,
  output logic [OCC_W-1:0]         occupancy,
  output logic [15:0]              stall_cycles,
  pipeline_stage_flush_if.slave    bus
);

  logic [ADDRESS_WIDTH-1:0] mem_address [DEPTH];
  logic [ID_WIDTH-1:0]      mem_id      [DEPTH];
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [OCC_W-1:0]         occ_q;
  logic [15:0]              stall_q;
  logic [ADDRESS_WIDTH-1:0] entry_address;
  logic                     full;
  logic                     push;
  logic                     pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    else return p + 1'b1;
  endfunction

  assign entry_address = (SUBTRACT != 0) ? (bus.in_address - stage_offset)
                                         : (bus.in_address + stage_offset);

  // out_stall depends only on registered occupancy, never on this cycle's inputs
  assign full          = (occ_q == OCC_W'(DEPTH));
  assign bus.out_stall = full;
  assign bus.out_valid = (occ_q != '0);
  assign push          = bus.in_valid && !full && !flush;
  assign pop           = bus.out_valid && !bus.in_stall && !flush;

  assign bus.out_address = mem_address[rd_ptr];
  assign bus.out_id      = mem_id[rd_ptr];
  assign occupancy       = occ_q;
  assign stall_cycles    = stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      stall_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_address[i] <= '0;
        mem_id[i]      <= '0;
      end
    end else begin
      if (flush) begin
        // Aligning wr_ptr to rd_ptr empties the queue without disturbing the head outputs
        occ_q  <= '0;
        wr_ptr <= rd_ptr;
      end else begin
        if (push) begin
          mem_address[wr_ptr] <= entry_address;
          mem_id[wr_ptr]      <= bus.in_id;
          wr_ptr              <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (push && !pop) begin
          occ_q <= occ_q + 1'b1;
        end else if (pop && !push) begin
          occ_q <= occ_q - 1'b1;
        end
      end
      if (bus.out_valid && bus.in_stall && !flush && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stage_flush.sv
// tb/tb_pipeline_stage_flush.sv - directed self-checking bench for pipeline_stage_flush
module tb_pipeline_stage_flush;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance: 32-bit address, DEPTH=2, add mode
  pipeline_stage_flush_if #(.ADDRESS_WIDTH(32), .ID_WIDTH(4)) bus ();
  logic [31:0] stage_offset;
  logic        flush;
  logic [1:0]  occupancy;
  logic [15:0] stall_cycles;

  pipeline_stage_flush #(.ADDRESS_WIDTH(32), .ID_WIDTH(4), .DEPTH(2), .SUBTRACT(0)) dut (
    .clk(clk), .reset(reset), .stage_offset(stage_offset), .flush(flush),
    .occupancy(occupancy), .stall_cycles(stall_cycles), .bus(bus)
  );

  // 8-bit instances for modular wrap in both offset modes
  pipeline_stage_flush_if #(.ADDRESS_WIDTH(8), .ID_WIDTH(4)) bus_sub ();
  pipeline_stage_flush_if #(.ADDRESS_WIDTH(8), .ID_WIDTH(4)) bus_add ();
  logic [7:0]  off_sub, off_add;
  logic [1:0]  occ_sub, occ_add;
  logic [15:0] sc_sub, sc_add;

  pipeline_stage_flush #(.ADDRESS_WIDTH(8), .ID_WIDTH(4), .DEPTH(2), .SUBTRACT(1)) dut_sub (
    .clk(clk), .reset(reset), .stage_offset(off_sub), .flush(1'b0),
    .occupancy(occ_sub), .stall_cycles(sc_sub), .bus(bus_sub)
  );

  pipeline_stage_flush #(.ADDRESS_WIDTH(8), .ID_WIDTH(4), .DEPTH(2), .SUBTRACT(0)) dut_add (
    .clk(clk), .reset(reset), .stage_offset(off_add), .flush(1'b0),
    .occupancy(occ_add), .stall_cycles(sc_add), .bus(bus_add)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [3:0] id);
    bus.in_valid   = v;
    bus.in_address = a;
    bus.in_id      = id;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    stage_offset = 32'h10;
    bus.in_stall = 1'b0;
    drive(1'b0, 32'h0, 4'h0);
    off_sub = 8'h10;
    off_add = 8'h02;
    bus_sub.in_valid = 1'b0; bus_sub.in_address = 8'h05; bus_sub.in_id = 4'h1; bus_sub.in_stall = 1'b1;
    bus_add.in_valid = 1'b0; bus_add.in_address = 8'hFF; bus_add.in_id = 4'h2; bus_add.in_stall = 1'b1;
    tick(2);
    reset = 1'b0;

    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_stall", 32'(bus.out_stall), 32'd0);
    check("rst_sc", 32'(stall_cycles), 32'd0);
    check("rst_addr", bus.out_address, 32'h0);
    check("rst_id", 32'(bus.out_id), 32'd0);

    // single pass-through with offset; 8-bit instances pushed alongside
    drive(1'b1, 32'h100, 4'd3);
    bus_sub.in_valid = 1'b1;
    bus_add.in_valid = 1'b1;
    tick();
    drive(1'b0, 32'hDEAD, 4'hF);
    bus_sub.in_valid = 1'b0;
    bus_add.in_valid = 1'b0;
    check("pass_addr", bus.out_address, 32'h110);
    check("pass_id", 32'(bus.out_id), 32'd3);
    check("pass_valid", 32'(bus.out_valid), 32'd1);
    check("sub8_addr", 32'(bus_sub.out_address), 32'hF5);
    check("add8_addr", 32'(bus_add.out_address), 32'h01);
    tick();
    check("pass_drain", 32'(bus.out_valid), 32'd0);
    check("pass_sc", 32'(stall_cycles), 32'd0);

    // fill under downstream stall, third held upstream, then ordered drain
    bus.in_stall = 1'b1;
    drive(1'b1, 32'h200, 4'd1);
    tick();
    check("fill1_occ", 32'(occupancy), 32'd1);
    drive(1'b1, 32'h300, 4'd2);
    tick();
    check("fill2_occ", 32'(occupancy), 32'd2);
    check("fill2_stall", 32'(bus.out_stall), 32'd1);
    check("fill2_sc", 32'(stall_cycles), 32'd1);
    drive(1'b1, 32'h400, 4'd3);
    tick();
    check("held_occ", 32'(occupancy), 32'd2);
    check("held_id", 32'(bus.out_id), 32'd1);
    check("held_addr", bus.out_address, 32'h210);
    bus.in_stall = 1'b0;
    tick();
    check("drain_id2", 32'(bus.out_id), 32'd2);
    check("drain_occ1", 32'(occupancy), 32'd1);
    check("drain_sc", 32'(stall_cycles), 32'd2);
    tick();
    drive(1'b0, 32'h0, 4'h0);
    check("drain_id3", 32'(bus.out_id), 32'd3);
    check("drain_addr3", bus.out_address, 32'h410);
    check("drain_occ_b", 32'(occupancy), 32'd1);
    tick();
    check("drain_empty", 32'(bus.out_valid), 32'd0);

    // simultaneous push and pop at occupancy 1
    drive(1'b1, 32'h0, 4'd5);
    tick();
    drive(1'b1, 32'h500, 4'd6);
    tick();
    drive(1'b0, 32'h0, 4'h0);
    check("pp_occ", 32'(occupancy), 32'd1);
    check("pp_id", 32'(bus.out_id), 32'd6);
    check("pp_addr", bus.out_address, 32'h510);

    // fill to 2, then flush with a concurrent input
    bus.in_stall = 1'b1;
    drive(1'b1, 32'h600, 4'd7);
    tick();
    check("pre_flush_occ", 32'(occupancy), 32'd2);
    check("pre_flush_sc", 32'(stall_cycles), 32'd3);
    drive(1'b1, 32'h700, 4'd8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 4'h0);
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_stall", 32'(bus.out_stall), 32'd0);
    check("flush_sc", 32'(stall_cycles), 32'd3);
    tick();
    check("post_flush_occ", 32'(occupancy), 32'd0);

    // build occupancy 2 and stall_cycles 7, then reset mid-stream
    drive(1'b1, 32'h800, 4'd9);
    tick();
    drive(1'b1, 32'h900, 4'd10);
    tick();
    drive(1'b0, 32'h0, 4'h0);
    tick(3);
    check("pre_rst_occ", 32'(occupancy), 32'd2);
    check("pre_rst_sc", 32'(stall_cycles), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_occ", 32'(occupancy), 32'd0);
    check("mid_rst_sc", 32'(stall_cycles), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_stall", 32'(bus.out_stall), 32'd0);
    check("mid_rst_addr", bus.out_address, 32'h0);
    check("mid_rst_id", 32'(bus.out_id), 32'd0);

    // saturation of the stall counter
    drive(1'b1, 32'hA00, 4'd11);
    tick();
    drive(1'b0, 32'h0, 4'h0);
    tick(65534);
    check("sat_below", 32'(stall_cycles), 32'hFFFE);
    tick();
    check("sat_reach", 32'(stall_cycles), 32'hFFFF);
    tick(2);
    check("sat_hold", 32'(stall_cycles), 32'hFFFF);
    check("sat_head_id", 32'(bus.out_id), 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
